// File: rtl/avalon_leds_pwm.sv
// Avalon-MM PWM output port: per-line duty (double-buffered, loaded at period wrap),
// enable mask and shared prescaler. Define AVALON_LEDS_PWM_SETCLR_EN for atomic ENABLE set/clear.
module avalon_leds_pwm #(
    parameter int CHANNELS      = 8,
    parameter int PWM_BITS      = 8,
    parameter int PRESCALE_BITS = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [4:0]          address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    output logic [CHANNELS-1:0] out_port
);

    localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'((2 ** PWM_BITS) - 2);

    logic [CHANNELS-1:0]      enable_q, enable_d;
    logic [PRESCALE_BITS-1:0] prescale_q, prescale_d;
    logic [PRESCALE_BITS-1:0] pre_cnt_q, pre_cnt_d;
    logic [PWM_BITS-1:0]      pwm_cnt_q, pwm_cnt_d;
    logic                     wrap_q, wrap_d;
    logic [PWM_BITS-1:0]      duty_q [CHANNELS];
    logic [PWM_BITS-1:0]      duty_d [CHANNELS];
    logic [PWM_BITS-1:0]      duty_active_q [CHANNELS];
    logic [PWM_BITS-1:0]      duty_active_d [CHANNELS];
    logic [CHANNELS-1:0]      out_q, out_d;

    logic wr;
    logic tick;
    logic wrap_tick;
    logic unused_wdata;

    assign wr           = chipselect && !write_n;
    assign tick         = (pre_cnt_q == prescale_q);
    assign wrap_tick    = tick && (pwm_cnt_q == CNT_LAST);
    assign unused_wdata = ^writedata;
    assign out_port     = out_q;

    always_comb begin
        readdata = '0;
        case (address)
            5'd0: readdata[CHANNELS-1:0]      = enable_q;
            5'd1: readdata[PRESCALE_BITS-1:0] = prescale_q;
            5'd2: readdata[0]                 = wrap_q;
            default: begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (address == 5'(8 + i)) readdata[PWM_BITS-1:0] = duty_q[i];
                end
            end
        endcase
    end

    always_comb begin
        enable_d   = enable_q;
        prescale_d = prescale_q;
        wrap_d     = wrap_q;
        duty_d     = duty_q;
        if (wr) begin
            case (address)
                5'd0: enable_d   = writedata[CHANNELS-1:0];
                5'd1: prescale_d = writedata[PRESCALE_BITS-1:0];
                5'd2: if (writedata[0]) wrap_d = 1'b0;
`ifdef AVALON_LEDS_PWM_SETCLR_EN
                5'd3: enable_d   = enable_q | writedata[CHANNELS-1:0];
                5'd4: enable_d   = enable_q & ~writedata[CHANNELS-1:0];
`endif
                default: begin
                    for (int i = 0; i < CHANNELS; i++) begin
                        if (address == 5'(8 + i)) duty_d[i] = writedata[PWM_BITS-1:0];
                    end
                end
            endcase
        end
        // A wrap in the same cycle as a clear leaves the flag set.
        if (wrap_tick) wrap_d = 1'b1;
    end

    always_comb begin
        if (wr && (address == 5'd1)) pre_cnt_d = '0;
        else if (tick)               pre_cnt_d = '0;
        else                         pre_cnt_d = pre_cnt_q + PRESCALE_BITS'(1);

        pwm_cnt_d     = pwm_cnt_q;
        duty_active_d = duty_active_q;
        if (wrap_tick) begin
            pwm_cnt_d     = '0;
            duty_active_d = duty_q;
        end else if (tick) begin
            pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        end

        // pwm_cnt never reaches MAX, so duty MAX is always high and duty 0 always low.
        for (int i = 0; i < CHANNELS; i++) begin
            out_d[i] = enable_q[i] && (pwm_cnt_q < duty_active_q[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_q   <= '0;
            prescale_q <= '0;
            pre_cnt_q  <= '0;
            pwm_cnt_q  <= '0;
            wrap_q     <= 1'b0;
            out_q      <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_q[i]        <= '0;
                duty_active_q[i] <= '0;
            end
        end else begin
            enable_q      <= enable_d;
            prescale_q    <= prescale_d;
            pre_cnt_q     <= pre_cnt_d;
            pwm_cnt_q     <= pwm_cnt_d;
            wrap_q        <= wrap_d;
            out_q         <= out_d;
            duty_q        <= duty_d;
            duty_active_q <= duty_active_d;
        end
    end

endmodule

// File: tb/tb_avalon_leds_pwm.sv
// Directed bench for avalon_leds_pwm with CHANNELS=4, PWM_BITS=4, run length measured on out_port.
module tb_avalon_leds_pwm;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [3:0]  out_port;

    int total = 0;
    int bad = 0;

    avalon_leds_pwm #(.CHANNELS(4), .PWM_BITS(4), .PRESCALE_BITS(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    // Called at a negedge; the write is captured on the next posedge, returns at the next negedge.
    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic do_read(input logic [4:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    // Waits for a low sample followed by a high sample on out_port[idx].
    task automatic wait_rise(input int idx, input int limit, output logic ok);
        int k = 0;
        while (out_port[idx] == 1'b1 && k < limit) begin @(negedge clk); k++; end
        while (out_port[idx] == 1'b0 && k < limit) begin @(negedge clk); k++; end
        ok = (out_port[idx] == 1'b1);
    endtask

    task automatic count_run(input int idx, input logic level, input int limit, output int n);
        n = 0;
        while (out_port[idx] == level && n < limit) begin n++; @(negedge clk); end
    endtask

    task automatic test_reset();
        logic [31:0] r;
        total++;
        if (out_port !== 4'h0) begin bad++; $display("FAIL reset_out: got %h want 0", out_port); end
        for (int a = 0; a < 4; a++) begin
            do_read(5'(a), r);
            total++;
            if (r !== 32'h0) begin bad++; $display("FAIL reset_read[%0d]: got %h want 0", a, r); end
        end
        do_read(5'd8, r);
        total++;
        if (r !== 32'h0) begin bad++; $display("FAIL reset_duty0: got %h want 0", r); end
    endtask

    task automatic test_duty5();
        logic [31:0] r;
        logic ok;
        int n;
        do_write(5'd8, 32'd5);
        do_read(5'd8, r);
        total++;
        if (r !== 32'd5) begin bad++; $display("FAIL duty0_readback: got %0d want 5", r); end
        do_write(5'd0, 32'h1);
        wait_rise(0, 60, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL duty5_rise: got %b want 1", ok); end
        for (int p = 0; p < 2; p++) begin
            count_run(0, 1'b1, 40, n);
            total++;
            if (n !== 5) begin bad++; $display("FAIL duty5_high[%0d]: got %0d want 5", p, n); end
            count_run(0, 1'b0, 40, n);
            total++;
            if (n !== 10) begin bad++; $display("FAIL duty5_low[%0d]: got %0d want 10", p, n); end
        end
        do_read(5'd2, r);
        total++;
        if (r !== 32'h1) begin bad++; $display("FAIL wrap_set: got %h want 1", r); end
        do_write(5'd2, 32'h1);
        do_read(5'd2, r);
        total++;
        if (r !== 32'h0) begin bad++; $display("FAIL wrap_clear: got %h want 0", r); end
    endtask

    task automatic test_boundaries();
        logic [31:0] r;
        int ones1 = 0;
        int ones2 = 0;
        do_write(5'd9, 32'd0);
        do_write(5'd10, 32'd15);
        do_write(5'd0, 32'hF);
        repeat (20) @(negedge clk);
        for (int k = 0; k < 45; k++) begin
            if (out_port[1]) ones1++;
            if (out_port[2]) ones2++;
            @(negedge clk);
        end
        total++;
        if (ones1 !== 0) begin bad++; $display("FAIL duty_zero: high %0d want 0", ones1); end
        total++;
        if (ones2 !== 45) begin bad++; $display("FAIL duty_max: high %0d want 45", ones2); end
        do_write(5'd11, 32'h1F);
        do_read(5'd11, r);
        total++;
        if (r !== 32'd15) begin bad++; $display("FAIL duty_trunc: got %0d want 15", r); end
        do_write(5'd12, 32'h7);
        do_read(5'd12, r);
        total++;
        if (r !== 32'h0) begin bad++; $display("FAIL unmapped_12: got %h want 0", r); end
        do_read(5'd5, r);
        total++;
        if (r !== 32'h0) begin bad++; $display("FAIL unmapped_5: got %h want 0", r); end
    endtask

    task automatic test_mid_change();
        logic ok;
        int n;
        int m;
        wait_rise(0, 60, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL mid_rise: got %b want 1", ok); end
        n = 1;
        do_write(5'd8, 32'd10);
        count_run(0, 1'b1, 40, m);
        n += m;
        total++;
        if (n !== 5) begin bad++; $display("FAIL mid_cur_high: got %0d want 5", n); end
        count_run(0, 1'b0, 40, n);
        total++;
        if (n !== 10) begin bad++; $display("FAIL mid_cur_low: got %0d want 10", n); end
        count_run(0, 1'b1, 40, n);
        total++;
        if (n !== 10) begin bad++; $display("FAIL mid_next_high: got %0d want 10", n); end
    endtask

    task automatic test_prescaler();
        logic [31:0] r;
        logic ok;
        int n;
        int m;
        do_write(5'd8, 32'd5);
        repeat (20) @(negedge clk);
        do_write(5'd1, 32'd3);
        do_read(5'd1, r);
        total++;
        if (r !== 32'd3) begin bad++; $display("FAIL prescale_readback: got %0d want 3", r); end
        wait_rise(0, 200, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL pre_rise: got %b want 1", ok); end
        count_run(0, 1'b1, 100, n);
        total++;
        if (n !== 20) begin bad++; $display("FAIL pre_high: got %0d want 20", n); end
        count_run(0, 1'b0, 100, n);
        total++;
        if (n !== 40) begin bad++; $display("FAIL pre_low: got %0d want 40", n); end
        // Rewrite lands when pre_cnt is 1, so the first step stretches by 2 clocks.
        n = 1;
        do_write(5'd1, 32'd3);
        count_run(0, 1'b1, 100, m);
        n += m;
        total++;
        if (n !== 22) begin bad++; $display("FAIL pre_restart_high: got %0d want 22", n); end
        do_write(5'd1, 32'd0);
    endtask

    task automatic test_enable_ops();
        logic [31:0] r;
        do_write(5'd0, 32'h5);
        do_read(5'd0, r);
        total++;
        if (r !== 32'h5) begin bad++; $display("FAIL enable_write: got %h want 5", r); end
        repeat (2) @(negedge clk);
        total++;
        if (out_port[2] !== 1'b1) begin bad++; $display("FAIL out2_on: got %b want 1", out_port[2]); end
`ifdef AVALON_LEDS_PWM_SETCLR_EN
        do_write(5'd3, 32'h2);
        do_read(5'd0, r);
        total++;
        if (r !== 32'h7) begin bad++; $display("FAIL enable_set: got %h want 7", r); end
        do_read(5'd3, r);
        total++;
        if (r !== 32'h0) begin bad++; $display("FAIL set_reads0: got %h want 0", r); end
        do_write(5'd4, 32'h4);
`else
        do_write(5'd3, 32'h2);
        do_read(5'd0, r);
        total++;
        if (r !== 32'h5) begin bad++; $display("FAIL addr3_ignored: got %h want 5", r); end
        do_write(5'd4, 32'h4);
        do_read(5'd0, r);
        total++;
        if (r !== 32'h5) begin bad++; $display("FAIL addr4_ignored: got %h want 5", r); end
        do_write(5'd0, 32'h3);
`endif
        total++;
        if (out_port[2] !== 1'b1) begin bad++; $display("FAIL out2_hold: got %b want 1", out_port[2]); end
        @(negedge clk);
        total++;
        if (out_port[2] !== 1'b0) begin bad++; $display("FAIL out2_drop: got %b want 0", out_port[2]); end
        do_read(5'd0, r);
        total++;
        if (r !== 32'h3) begin bad++; $display("FAIL enable_after_clr: got %h want 3", r); end
        do_read(5'd4, r);
        total++;
        if (r !== 32'h0) begin bad++; $display("FAIL addr4_reads0: got %h want 0", r); end
    endtask

    task automatic test_async_reset();
        logic [31:0] r;
        logic [4:0] addrs [5] = '{5'd0, 5'd1, 5'd2, 5'd8, 5'd10};
        do_write(5'd0, 32'h4);
        repeat (2) @(negedge clk);
        total++;
        if (out_port !== 4'h4) begin bad++; $display("FAIL pre_reset_out: got %h want 4", out_port); end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (out_port !== 4'h0) begin bad++; $display("FAIL async_reset_out: got %h want 0", out_port); end
        for (int k = 0; k < 5; k++) begin
            do_read(addrs[k], r);
            total++;
            if (r !== 32'h0) begin bad++; $display("FAIL async_reset_read[%0d]: got %h want 0", addrs[k], r); end
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        total++;
        if (out_port !== 4'h0) begin bad++; $display("FAIL post_reset_out: got %h want 0", out_port); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        @(negedge clk);
        test_duty5();
        test_boundaries();
        test_mid_change();
        test_prescaler();
        test_enable_ops();
        @(negedge clk);
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
